// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP update scheduler.
// Holds the FSM encoding, the pending-request record and the saturating weight step.
package stdp_pkg;

    localparam int unsigned PEND_DT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        CALC,
        WRITE
    } state_t;

    typedef struct packed {
        logic                 dir;
        logic [PEND_DT_W-1:0] dt;
    } pend_t;

    // Step size halves for every 8 cycles of pairing distance.
    function automatic logic [7:0] step_mag(input logic [7:0] a, input logic [PEND_DT_W-1:0] dt);
        return a >> (dt >> 3);
    endfunction

    function automatic logic [7:0] sat_update(input logic [7:0] w, input logic [7:0] mag,
                                              input logic dir);
        logic [8:0] res;
        if (dir) begin
            res = {1'b0, w} + {1'b0, mag};
            return res[8] ? 8'hFF : res[7:0];
        end else begin
            res = {1'b0, w} - {1'b0, mag};
            return res[8] ? 8'h00 : res[7:0];
        end
    endfunction

endpackage

// File: rtl/stdp_rr_arbiter.sv
// N-way round-robin arbiter: searches upward from ptr, wrapping, for the first request.
// Grant is one-hot and only asserted when grant_en is high.
module stdp_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 grant_en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    int unsigned j;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        found = 1'b0;
        j     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            j = off + 32'(ptr);
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        if (grant_en && any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/stdp_update_sched.sv
// STDP learning scheduler: per-synapse spike timing, pending pair requests,
// round-robin arbitration into one weight-update engine owning the weight file.
module stdp_update_sched
    import stdp_pkg::*;
#(
    parameter int unsigned N_SYN       = 4,
    parameter int unsigned DT_W        = 8,
    parameter int unsigned DT_WINDOW   = 32,
    parameter int unsigned A_PLUS      = 8,
    parameter int unsigned A_MINUS     = 4,
    parameter logic [7:0]  WEIGHT_INIT = 8'h80
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_SYN-1:0]         pre_spike,
    input  logic                     post_spike,
    input  logic                     learn_en,
    output logic [8*N_SYN-1:0]       weight_flat,
    output logic                     upd_valid,
    output logic [$clog2(N_SYN)-1:0] upd_idx,
    output logic                     upd_dir,
    output logic                     busy
);

    localparam int unsigned      IDX_W = $clog2(N_SYN);
    localparam logic [DT_W-1:0]  WIN   = DT_W'(DT_WINDOW);
    localparam logic [7:0]       A_P8  = 8'(A_PLUS);
    localparam logic [7:0]       A_M8  = 8'(A_MINUS);

    logic [N_SYN-1:0] prev_pre;
    logic             prev_post;
    logic [N_SYN-1:0] pre_edge;
    logic             post_edge;
    logic [DT_W-1:0]  pre_age [N_SYN];
    logic [DT_W-1:0]  post_age;

    logic [N_SYN-1:0] pend_vld;
    logic [N_SYN-1:0] pend_set;
    pend_t            pend     [N_SYN];
    pend_t            pend_new [N_SYN];

    logic [7:0]       weight [N_SYN];
    logic [7:0]       w_hold;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, gnt_idx;
    logic [N_SYN-1:0] grant;
    logic             gnt_any, grant_en;

    assign pre_edge  = pre_spike & ~prev_pre;
    assign post_edge = post_spike & ~prev_post;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_pre  <= '0;
            prev_post <= 1'b0;
            post_age  <= WIN;
            for (int unsigned i = 0; i < N_SYN; i++) pre_age[i] <= WIN;
        end else begin
            prev_pre  <= pre_spike;
            prev_post <= post_spike;
            if (post_edge)           post_age <= DT_W'(1);
            else if (post_age < WIN) post_age <= post_age + DT_W'(1);
            for (int unsigned i = 0; i < N_SYN; i++) begin
                if (pre_edge[i])           pre_age[i] <= DT_W'(1);
                else if (pre_age[i] < WIN) pre_age[i] <= pre_age[i] + DT_W'(1);
            end
        end
    end

    // Pot and dep are mutually exclusive: each needs its own edge without the other.
    always_comb begin
        pend_set = '0;
        for (int unsigned i = 0; i < N_SYN; i++) begin
            pend_new[i] = '0;
            if (learn_en && post_edge && !pre_edge[i] && (pre_age[i] < WIN)) begin
                pend_set[i]    = 1'b1;
                pend_new[i].dir = 1'b1;
                pend_new[i].dt  = PEND_DT_W'(pre_age[i]);
            end else if (learn_en && pre_edge[i] && !post_edge && (post_age < WIN)) begin
                pend_set[i]    = 1'b1;
                pend_new[i].dir = 1'b0;
                pend_new[i].dt  = PEND_DT_W'(post_age);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld <= '0;
            for (int unsigned i = 0; i < N_SYN; i++) pend[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SYN; i++) begin
                if (pend_set[i]) begin
                    pend_vld[i] <= 1'b1;
                    pend[i]     <= pend_new[i];
                end else if (grant[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
        end
    end

    stdp_rr_arbiter #(
        .N (N_SYN)
    ) u_arb (
        .req      (pend_vld),
        .ptr      (ptr),
        .grant_en (grant_en),
        .grant    (grant),
        .idx      (gnt_idx),
        .any      (gnt_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_any) state_nxt = SEL;
            SEL:     state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_en  = (state == SEL);
        upd_valid = (state == WRITE);
        busy      = (state != IDLE) || gnt_any;
    end

    // The held weight is computed straight from the granted slot, so the capture
    // and the arithmetic share the SEL edge and the commit lands one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            upd_idx <= '0;
            upd_dir <= 1'b0;
            w_hold  <= '0;
            for (int unsigned i = 0; i < N_SYN; i++) weight[i] <= WEIGHT_INIT;
        end else begin
            if (grant_en) begin
                upd_idx <= gnt_idx;
                upd_dir <= pend[gnt_idx].dir;
                ptr     <= (gnt_idx == IDX_W'(N_SYN - 1)) ? '0 : gnt_idx + IDX_W'(1);
                w_hold  <= sat_update(weight[gnt_idx],
                                      step_mag(pend[gnt_idx].dir ? A_P8 : A_M8, pend[gnt_idx].dt),
                                      pend[gnt_idx].dir);
            end
            if (state == CALC) weight[upd_idx] <= w_hold;
        end
    end

    always_comb begin
        weight_flat = '0;
        for (int unsigned i = 0; i < N_SYN; i++) weight_flat[8*i +: 8] = weight[i];
    end

endmodule

// File: tb/tb_stdp_update_sched.sv
// Directed bench for stdp_update_sched: each task drives a scenario and checks
// hand-computed weights, strobes and busy against the timing of the block.
module tb_stdp_update_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  pre_spike = '0;
    logic        post_spike = 1'b0;
    logic        learn_en = 1'b1;
    logic [31:0] weight_flat;
    logic        upd_valid;
    logic [1:0]  upd_idx;
    logic        upd_dir;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    stdp_update_sched #(
        .N_SYN       (4),
        .DT_W        (8),
        .DT_WINDOW   (32),
        .A_PLUS      (8),
        .A_MINUS     (4),
        .WEIGHT_INIT (8'h80)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .learn_en    (learn_en),
        .weight_flat (weight_flat),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_dir     (upd_dir),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] w(input int i);
        return weight_flat[8*i +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1;
        step(); step();
        reset_n = 1'b1;
    endtask

    // Potentiation pairing with the pre edge masked from producing a depression.
    task automatic pot_pair(input int syn, input int dt);
        learn_en = 1'b0; pre_spike[syn] = 1'b1; step();
        pre_spike = '0; learn_en = 1'b1;
        repeat (dt - 1) step();
        post_spike = 1'b1; step();
        post_spike = 1'b0;
        repeat (4) step();
    endtask

    task automatic dep_pair(input int syn, input int dt);
        learn_en = 1'b0; post_spike = 1'b1; step();
        post_spike = 1'b0; learn_en = 1'b1;
        repeat (dt - 1) step();
        pre_spike[syn] = 1'b1; step();
        pre_spike = '0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", upd_valid); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (w(i) !== 8'h80) begin n_fail++; $display("FAIL reset_weight%0d: got %h want 80", i, w(i)); end
        end
    endtask

    task automatic test_reset_mid_update();
        do_reset();
        pot_pair(0, 1);
        n_checks++; if (w(0) !== 8'h88) begin n_fail++; $display("FAIL mid_pre_w0: got %h want 88", w(0)); end
        pre_spike = 4'b0010; step(); pre_spike = '0;
        post_spike = 1'b1; step(); post_spike = 1'b0;
        step(); step();
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", upd_valid); end
        n_checks++; if (w(0) !== 8'h80) begin n_fail++; $display("FAIL mid_reset_w0: got %h want 80", w(0)); end
        step(); reset_n = 1'b1;
        repeat (6) step();
        n_checks++; if (weight_flat !== 32'h80808080) begin n_fail++; $display("FAIL mid_after_weights: got %h want 80808080", weight_flat); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_busy: got %b want 0", busy); end
    endtask

    task automatic test_potentiation();
        do_reset();
        pre_spike = 4'b0001; step(); pre_spike = '0;
        repeat (4) step();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pot_busy_rise: got %b want 1", busy); end
        step(); step();
        n_checks++; if (w(0) !== 8'h80 || upd_valid !== 1'b0) begin
            n_fail++; $display("FAIL pot_early: got w0=%h valid=%b want 80/0", w(0), upd_valid); end
        step();
        n_checks++; if (w(0) !== 8'h88) begin n_fail++; $display("FAIL pot_w0: got %h want 88", w(0)); end
        n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 2'd0 || upd_dir !== 1'b1) begin
            n_fail++; $display("FAIL pot_strobe: got v=%b idx=%0d dir=%b want 1/0/1", upd_valid, upd_idx, upd_dir); end
        step();
        n_checks++; if (upd_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL pot_done: got v=%b busy=%b want 0/0", upd_valid, busy); end
    endtask

    task automatic test_depression();
        do_reset();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        repeat (9) step();
        pre_spike = 4'b0010; step(); pre_spike = '0;
        repeat (3) step();
        n_checks++; if (w(1) !== 8'h7E) begin n_fail++; $display("FAIL dep_w1: got %h want 7e", w(1)); end
        n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 2'd1 || upd_dir !== 1'b0) begin
            n_fail++; $display("FAIL dep_strobe: got v=%b idx=%0d dir=%b want 1/1/0", upd_valid, upd_idx, upd_dir); end
        do_reset();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        repeat (39) step();
        pre_spike = 4'b0010; step(); pre_spike = '0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dep_window_busy: got %b want 0", busy); end
        repeat (5) step();
        n_checks++; if (w(1) !== 8'h80) begin n_fail++; $display("FAIL dep_window_w1: got %h want 80", w(1)); end
    endtask

    task automatic test_arbitration();
        logic [7:0] exp_w;
        do_reset();
        pre_spike = 4'b1111; step(); pre_spike = '0;
        step(); step();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (3) step();
            n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 2'(k) || upd_dir !== 1'b1) begin
                n_fail++; $display("FAIL arb_order%0d: got v=%b idx=%0d dir=%b want 1/%0d/1", k, upd_valid, upd_idx, upd_dir, k); end
            n_checks++; if (w(k) !== 8'h88) begin n_fail++; $display("FAIL arb_w%0d: got %h want 88", k, w(k)); end
            if (k < 3) begin
                exp_w = 8'h80;
                n_checks++; if (w(k + 1) !== exp_w) begin n_fail++; $display("FAIL arb_next%0d: got %h want 80", k + 1, w(k + 1)); end
            end
            step();
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arb_busy_end: got %b want 0", busy); end
        // Leave ptr at 2, then requests on 0 and 3 must resolve 3 first.
        do_reset();
        pre_spike = 4'b0010; step(); pre_spike = '0;
        post_spike = 1'b1; step(); post_spike = 1'b0;
        repeat (3) step();
        n_checks++; if (upd_idx !== 2'd1 || w(1) !== 8'h88) begin
            n_fail++; $display("FAIL arb_rr_first: got idx=%0d w1=%h want 1/88", upd_idx, w(1)); end
        repeat (40) step();
        pre_spike = 4'b1001; step(); pre_spike = '0;
        post_spike = 1'b1; step(); post_spike = 1'b0;
        repeat (3) step();
        n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 2'd3 || w(3) !== 8'h88) begin
            n_fail++; $display("FAIL arb_rr_wrap3: got v=%b idx=%0d w3=%h want 1/3/88", upd_valid, upd_idx, w(3)); end
        repeat (4) step();
        n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 2'd0 || w(0) !== 8'h88) begin
            n_fail++; $display("FAIL arb_rr_wrap0: got v=%b idx=%0d w0=%h want 1/0/88", upd_valid, upd_idx, w(0)); end
        n_checks++; if (w(1) !== 8'h88) begin n_fail++; $display("FAIL arb_rr_w1: got %h want 88", w(1)); end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (15) pot_pair(0, 1);
        n_checks++; if (w(0) !== 8'hF8) begin n_fail++; $display("FAIL sat_w0_f8: got %h want f8", w(0)); end
        pot_pair(0, 8);
        n_checks++; if (w(0) !== 8'hFC) begin n_fail++; $display("FAIL sat_w0_fc: got %h want fc", w(0)); end
        pot_pair(0, 1);
        n_checks++; if (w(0) !== 8'hFF) begin n_fail++; $display("FAIL sat_w0_ff: got %h want ff", w(0)); end
        repeat (31) dep_pair(1, 1);
        n_checks++; if (w(1) !== 8'h04) begin n_fail++; $display("FAIL sat_w1_04: got %h want 04", w(1)); end
        dep_pair(1, 8);
        n_checks++; if (w(1) !== 8'h02) begin n_fail++; $display("FAIL sat_w1_02: got %h want 02", w(1)); end
        dep_pair(1, 1);
        n_checks++; if (w(1) !== 8'h00) begin n_fail++; $display("FAIL sat_w1_00: got %h want 00", w(1)); end
        n_checks++; if (w(0) !== 8'hFF || w(2) !== 8'h80) begin
            n_fail++; $display("FAIL sat_others: got w0=%h w2=%h want ff/80", w(0), w(2)); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pre_spike = 4'b0101; step(); pre_spike = '0;
        step();
        pre_spike = 4'b0100; post_spike = 1'b1; step();
        pre_spike = '0; post_spike = 1'b0;
        repeat (3) step();
        n_checks++; if (upd_idx !== 2'd0 || w(0) !== 8'h88) begin
            n_fail++; $display("FAIL sim_w0: got idx=%0d w0=%h want 0/88", upd_idx, w(0)); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_busy: got %b want 0", busy); end
        repeat (4) step();
        n_checks++; if (w(2) !== 8'h80) begin n_fail++; $display("FAIL sim_w2: got %h want 80", w(2)); end
    endtask

    task automatic test_learn_en();
        do_reset();
        pre_spike = 4'b0011; step(); pre_spike = '0;
        step();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        learn_en = 1'b0;
        repeat (3) step();
        n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 2'd0 || w(0) !== 8'h88) begin
            n_fail++; $display("FAIL len_w0: got v=%b idx=%0d w0=%h want 1/0/88", upd_valid, upd_idx, w(0)); end
        repeat (4) step();
        n_checks++; if (upd_valid !== 1'b1 || upd_idx !== 2'd1 || w(1) !== 8'h88) begin
            n_fail++; $display("FAIL len_w1: got v=%b idx=%0d w1=%h want 1/1/88", upd_valid, upd_idx, w(1)); end
        step();
        pre_spike = 4'b0100; step(); pre_spike = '0;
        step();
        post_spike = 1'b1; step(); post_spike = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len_blocked_busy: got %b want 0", busy); end
        repeat (5) step();
        n_checks++; if (weight_flat !== 32'h80808888) begin
            n_fail++; $display("FAIL len_blocked_weights: got %h want 80808888", weight_flat); end
        learn_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_potentiation();
        test_depression();
        test_arbitration();
        test_saturation();
        test_simultaneous();
        test_learn_en();
        test_reset_mid_update();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stdp_update_sched.md
# stdp_update_sched

Shared-datapath STDP learning scheduler for N_SYN synapses converging on one postsynaptic neuron. It timestamps pre- and postsynaptic spike edges per synapse and turns each qualifying pair into a potentiation or depression request. Pending requests are arbitrated round-robin into a single weight-update engine, and the block owns the N_SYN-entry 8-bit weight file. It sits between the spike sources and the neuron's weighted-input summation.

## Interface
- N_SYN, 4: synapse count, ≥2
- DT_W, 8: width of age counters
- DT_WINDOW, 32: pairing window in cycles; power of two, ≤2^DT_W−1
- A_PLUS, 8: potentiation step at dt<8
- A_MINUS, 4: depression step at dt<8
- WEIGHT_INIT, 8'h80: reset value of every weight

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pre_spike  in  N_SYN  presynaptic spike levels, bit i = synapse i
- post_spike  in  1  postsynaptic spike level
- learn_en  in  1  1 = new requests may be generated
- weight_flat  out  8*N_SYN  weights; bits [8i+7:8i] = synapse i
- upd_valid  out  1  high in WRITE state
- upd_idx  out  clog2(N_SYN)  synapse being written
- upd_dir  out  1  1 = potentiation, 0 = depression
- busy  out  1  FSM not IDLE or any request pending

## Operation
- Edge detection: a spike counts on a rising edge, i.e. input high while its registered previous value is low.
- Ages: pre_age[i] and post_age saturate at DT_WINDOW.
  - Loaded with 1 on their own spike edge; otherwise +1 per cycle.
  - Reset value is DT_WINDOW. An age is valid iff < DT_WINDOW.
  - The dt used for a pairing is the register value before that edge's update.
- Potentiation: on a post edge with learn_en=1, every synapse i with valid pre_age[i] and no pre edge in the same cycle gets pending[i] = {dir=1, dt=pre_age[i]}.
- Depression: on a pre edge for synapse i with learn_en=1, valid post_age and no post edge in the same cycle gives pending[i] = {dir=0, dt=post_age}.
- Simultaneous pre and post edges on synapse i: no request for i; both ages still reload to 1.
- One pending slot per synapse. A new request overwrites the slot (latest wins).
  - A request set in the same cycle the slot is granted survives (set beats clear).
- learn_en=0 blocks new requests only. Pending requests and in-flight updates still complete.
- Magnitude: mag = A >> (dt >> 3), where A = A_PLUS or A_MINUS. This halves the step every 8 cycles of dt.
- Weight update is saturating 9-bit arithmetic:
  - potentiation: min(w+mag, 255)
  - depression: max(w−mag, 0)
- FSM:
  - IDLE → SEL when any pending bit is set.
  - SEL: round-robin pick starting at ptr; capture idx/dir/dt; clear that pending bit; ptr ← idx+1 mod N_SYN.
  - SEL → CALC: compute the new weight into a holding register.
  - CALC → WRITE: commit to the weight file.
  - WRITE → IDLE.
- Reset mid-operation returns everything to reset state immediately: FSM IDLE, ptr 0, pending cleared, ages DT_WINDOW, prev-spike registers 0, weights WEIGHT_INIT, upd_valid 0, busy 0.

## Timing
- Request registered at the spike edge E.
- SEL at E+1, CALC at E+2.
- Weight visible on weight_flat from E+3, with upd_valid high for cycle E+3.
- Throughput: one update per 4 cycles. With k requests pending, the last commits within 4k cycles.
- upd_idx and upd_dir hold the captured values from SEL until the next SEL. They are meaningful only while upd_valid=1.
- busy rises at E (combinational from pending) and falls in the cycle after the last WRITE.

## Structure
- Package stdp_pkg holds:
  - the FSM state enum (IDLE, SEL, CALC, WRITE)
  - the pending-request struct {dir, dt}
  - the magnitude-shift and saturation helper functions
- One sub-module, stdp_rr_arbiter: N-way round-robin.
  - Inputs: req vector, ptr, grant_en.
  - Outputs: one-hot grant, encoded idx, any.
- Ages, edge detect, pending slots and weight file stay in the top level.

## Test plan
- Reset: hold reset_n low mid-update, release → all weights 0x80, busy=0, upd_valid=0.
- Potentiation: pre[0] edge at cycle 0, post edge at cycle 5 → dt=5, mag=8, weight0=0x88 at cycle 8, upd_valid=1 with upd_idx=0, upd_dir=1.
- Depression and decay: post edge at cycle 0, pre[1] edge at cycle 10 → dt=10, mag=2, weight1=0x7E. A pre at dt=40 (outside window) → no update.
- Arbitration: pre on all 4 synapses at cycle 0, post at cycle 3 → commits in idx order 0,1,2,3, 4 cycles apart. A second round starts at ptr after the last grant.
- Saturation and simultaneity:
  - weight at 0xFC plus potentiation with mag 8 → 0xFF
  - weight 0x02 minus 4 → 0x00
  - pre[2] and post in the same cycle → no request for synapse 2
- learn_en: drop learn_en the cycle after a post edge → already-pending updates still commit; spike pairs while learn_en=0 leave weights unchanged.
